// File: rtl/uart_tx_fifo_if.sv
// Valid/ready word handshake feeding the buffered UART transmitter.
interface uart_tx_fifo_if #(
  parameter int DATA_SIZE = 8
);
  logic                 valid_in;
  logic [DATA_SIZE-1:0] data_in;
  logic                 ready_out;

  modport master (output valid_in, output data_in, input ready_out);
  modport slave  (input valid_in, input data_in, output ready_out);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed, LSB-first framing with per-frame latched
// divisor, parity mode and stop-bit count; queued frames go out back-to-back.
module uart_tx_fifo #(
  parameter int DATA_SIZE  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  uart_tx_fifo_if.slave                     bus,
  input  logic [DIV_WIDTH-1:0]              baud_div_in,
  input  logic [1:0]                        parity_mode_in,
  input  logic                              two_stop_in,
  output logic                              tx_out,
  output logic                              busy_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_out
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int BIT_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_SIZE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Divisors below 2 would give a zero-length bit period.
  function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] d);
    return (d < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : d;
  endfunction

  logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [DATA_SIZE-1:0] head, shreg;
  logic                 push, pop, shift, bit_end, last_stop;

  state_t               state;
  logic [DIV_WIDTH-1:0] baud_cnt, div_q;
  logic [BIT_W-1:0]     bit_idx;
  logic                 stop_second, par_en_q, par_bit_q, two_q, tx_q;

  assign bus.ready_out  = (count < CNT_W'(FIFO_DEPTH));
  assign push           = bus.valid_in && bus.ready_out;
  assign head           = mem[rd_ptr];
  assign bit_end        = (baud_cnt == div_q - DIV_WIDTH'(1));
  assign last_stop      = (state == STOP) && bit_end && (!two_q || stop_second);
  assign pop            = (count != '0) && ((state == IDLE) || last_stop);
  assign shift          = bit_end && ((state == START) ||
                                      ((state == DATA) && (bit_idx != LAST_BIT)));
  assign tx_out         = tx_q;
  assign busy_out       = (state != IDLE) || (count != '0);
  assign fifo_count_out = count;

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Bit 0 leaves the shifter as the start bit ends; each data bit boundary exposes the next.
  always_ff @(posedge clk_in) begin
    if (pop)        shreg <= head;
    else if (shift) shreg <= shreg >> 1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= IDLE;
      tx_q        <= 1'b1;
      baud_cnt    <= '0;
      div_q       <= DIV_WIDTH'(2);
      bit_idx     <= '0;
      stop_second <= 1'b0;
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
      two_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
        end
        START: if (bit_end) begin
          state   <= DATA;
          tx_q    <= shreg[0];
          bit_idx <= '0;
        end
        DATA: if (bit_end) begin
          if (bit_idx == LAST_BIT) begin
            if (par_en_q) begin
              state <= PARITY;
              tx_q  <= par_bit_q;
            end else begin
              state       <= STOP;
              tx_q        <= 1'b1;
              stop_second <= 1'b0;
            end
          end else begin
            bit_idx <= bit_idx + BIT_W'(1);
            tx_q    <= shreg[0];
          end
        end
        PARITY: if (bit_end) begin
          state       <= STOP;
          tx_q        <= 1'b1;
          stop_second <= 1'b0;
        end
        STOP: if (bit_end) begin
          if (two_q && !stop_second) begin
            stop_second <= 1'b1;
          end else begin
            state <= IDLE;
            tx_q  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase
      baud_cnt <= ((state == IDLE) || bit_end) ? '0 : baud_cnt + DIV_WIDTH'(1);
      // A pop overrides the above: new frame config and start bit take effect together.
      if (pop) begin
        state     <= START;
        tx_q      <= 1'b0;
        baud_cnt  <= '0;
        div_q     <= clamp_div(baud_div_in);
        par_en_q  <= (parity_mode_in == 2'b01) || (parity_mode_in == 2'b10);
        par_bit_q <= (^head) ^ (parity_mode_in == 2'b10);
        two_q     <= two_stop_in;
      end
    end
  end
endmodule
